// File: rtl/retire_pkg.sv
// Shared types for the retire trace path: record kinds, the queued record
// layout and the kind classifier used at the MEM/WB boundary.
package retire_pkg;

  localparam int REC_PC_W   = 16;
  localparam int REC_DATA_W = 16;
  localparam int REC_INUM_W = 32;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ALU  = 3'd1,
    LD   = 3'd2,
    ST   = 3'd3,
    STU  = 3'd4,
    HALT = 3'd5
  } retire_kind_e;

  typedef struct packed {
    logic [REC_INUM_W-1:0] inum;
    logic [REC_PC_W-1:0]   pc;
    retire_kind_e          kind;
    logic [2:0]            reg_idx;
    logic [REC_DATA_W-1:0] reg_data;
    logic [REC_DATA_W-1:0] mem_addr;
    logic [REC_DATA_W-1:0] mem_data;
  } retire_rec_t;

  // Priority order matters: halt dominates, then combined reg+mem forms.
  function automatic retire_kind_e classify(input logic halt, input logic reg_wr,
                                            input logic mem_rd, input logic mem_wr);
    if (halt)                 return HALT;
    else if (reg_wr && mem_wr) return STU;
    else if (reg_wr && mem_rd) return LD;
    else if (reg_wr)          return ALU;
    else if (mem_wr)          return ST;
    else                      return NOP;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. Storage is a plain array with a registered
// read; the head register is loaded from the next-state read pointer so the
// head is valid the cycle after a push into an empty FIFO.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);
  import retire_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] head_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_reg;
  assign head    = head_reg;

  // Next-state read pointer and occupancy.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_pop) rd_ptr_next = rd_ptr_reg + 1'b1;
    if (do_push && !do_pop)      count_next = count_reg + 1'b1;
    else if (!do_push && do_pop) count_next = count_reg - 1'b1;
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Head register: forward the entry being written when it becomes the head.
  always_ff @(posedge clk) begin
    if (rst || count_next == '0) begin
      head_reg <= '0;
    end else if (do_push && wr_ptr_reg == rd_ptr_next) begin
      head_reg <= push_data;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: classifies each retire event, numbers it, and
// queues it for a valid/ready consumer with stall, overflow and halt tracking.
module retire_trace_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int INUM_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [15:0]                in_pc,
  input  logic                       in_reg_wr,
  input  logic [2:0]                 in_reg_idx,
  input  logic [DATA_W-1:0]          in_reg_data,
  input  logic                       in_mem_rd,
  input  logic                       in_mem_wr,
  input  logic [DATA_W-1:0]          in_mem_addr,
  input  logic [DATA_W-1:0]          in_mem_data,
  input  logic                       in_halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INUM_W-1:0]          out_inum,
  output logic [15:0]                out_pc,
  output logic [2:0]                 out_kind,
  output logic [2:0]                 out_reg_idx,
  output logic [DATA_W-1:0]          out_reg_data,
  output logic [DATA_W-1:0]          out_mem_addr,
  output logic [DATA_W-1:0]          out_mem_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stall_req,
  output logic                       overflow,
  output logic                       halted
);
  import retire_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  retire_kind_e     in_kind;
  retire_rec_t      in_rec;
  retire_rec_t      head;
  logic [INUM_W-1:0] inum_reg;
  logic             halt_seen_reg;
  logic             overflow_reg;
  logic             halted_reg;
  logic             stall_req_reg;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;

  assign in_kind = classify(in_halt, in_reg_wr, in_mem_rd, in_mem_wr);
  assign accept  = in_valid & ~halt_seen_reg;
  assign pop     = ~empty & out_ready;
  assign push    = accept & (~full | pop);

  // Build the record, zeroing fields that do not apply to its kind.
  always_comb begin
    in_rec      = '0;
    in_rec.inum = inum_reg;
    in_rec.pc   = in_pc;
    in_rec.kind = in_kind;
    case (in_kind)
      ALU: begin
        in_rec.reg_idx  = in_reg_idx;
        in_rec.reg_data = in_reg_data;
      end
      LD: begin
        in_rec.reg_idx  = in_reg_idx;
        in_rec.reg_data = in_reg_data;
        in_rec.mem_addr = in_mem_addr;
      end
      STU: begin
        in_rec.reg_idx  = in_reg_idx;
        in_rec.reg_data = in_reg_data;
        in_rec.mem_addr = in_mem_addr;
        in_rec.mem_data = in_mem_data;
      end
      ST: begin
        in_rec.mem_addr = in_mem_addr;
        in_rec.mem_data = in_mem_data;
      end
      default: ;
    endcase
  end

  // Occupancy after this edge, used to register the almost-full stall.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + 1'b1;
    else if (!push && pop) count_next = fifo_count - 1'b1;
  end

  sync_fifo #(
    .WIDTH ($bits(retire_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_rec),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .head      (head)
  );

  // INUM counter, sticky overflow, halt bookkeeping and registered stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      inum_reg      <= '0;
      halt_seen_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      halted_reg    <= 1'b0;
      stall_req_reg <= 1'b0;
    end else begin
      if (accept) inum_reg <= inum_reg + 1'b1;
      if (accept && in_kind == HALT) halt_seen_reg <= 1'b1;
      if (accept && full && !pop) overflow_reg <= 1'b1;
      if (pop && head.kind == HALT) halted_reg <= 1'b1;
      stall_req_reg <= (count_next >= CNT_W'(DEPTH-1));
    end
  end

  assign out_valid    = ~empty;
  assign out_inum     = head.inum;
  assign out_pc       = head.pc;
  assign out_kind     = head.kind;
  assign out_reg_idx  = head.reg_idx;
  assign out_reg_data = head.reg_data;
  assign out_mem_addr = head.mem_addr;
  assign out_mem_data = head.mem_data;
  assign count        = fifo_count;
  assign stall_req    = stall_req_reg;
  assign overflow     = overflow_reg;
  assign halted       = halted_reg;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios plus randomized traffic,
// all compared each cycle against a queue-based reference model.
module tb_retire_trace_buffer;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int INUM_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int K_NOP = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_STU = 4, K_HALT = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [15:0]       in_pc;
  logic              in_reg_wr;
  logic [2:0]        in_reg_idx;
  logic [DATA_W-1:0] in_reg_data;
  logic              in_mem_rd;
  logic              in_mem_wr;
  logic [DATA_W-1:0] in_mem_addr;
  logic [DATA_W-1:0] in_mem_data;
  logic              in_halt;
  logic              out_valid;
  logic              out_ready;
  logic [INUM_W-1:0] out_inum;
  logic [15:0]       out_pc;
  logic [2:0]        out_kind;
  logic [2:0]        out_reg_idx;
  logic [DATA_W-1:0] out_reg_data;
  logic [DATA_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_data;
  logic [CNT_W-1:0]  count;
  logic              stall_req;
  logic              overflow;
  logic              halted;

  retire_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INUM_W(INUM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
    .in_reg_wr(in_reg_wr), .in_reg_idx(in_reg_idx), .in_reg_data(in_reg_data),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_mem_addr(in_mem_addr),
    .in_mem_data(in_mem_data), .in_halt(in_halt), .out_valid(out_valid),
    .out_ready(out_ready), .out_inum(out_inum), .out_pc(out_pc),
    .out_kind(out_kind), .out_reg_idx(out_reg_idx), .out_reg_data(out_reg_data),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data), .count(count),
    .stall_req(stall_req), .overflow(overflow), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned inum;
    int unsigned pc;
    int unsigned kind;
    int unsigned reg_idx;
    int unsigned reg_data;
    int unsigned mem_addr;
    int unsigned mem_data;
  } rec_t;

  rec_t        q[$];
  int unsigned m_inum;
  bit          m_halt_seen;
  bit          m_ovf;
  bit          m_halted;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Record the spec says the current inputs should produce.
  function automatic rec_t expected_rec();
    rec_t r;
    r = '{default: 0};
    r.inum = m_inum;
    r.pc   = in_pc;
    if (in_halt)                      r.kind = K_HALT;
    else if (in_reg_wr && in_mem_wr)  r.kind = K_STU;
    else if (in_reg_wr && in_mem_rd)  r.kind = K_LD;
    else if (in_reg_wr)               r.kind = K_ALU;
    else if (in_mem_wr)               r.kind = K_ST;
    else                              r.kind = K_NOP;
    if (r.kind inside {K_ALU, K_LD, K_STU}) begin
      r.reg_idx  = in_reg_idx;
      r.reg_data = in_reg_data;
    end
    if (r.kind inside {K_LD, K_ST, K_STU}) r.mem_addr = in_mem_addr;
    if (r.kind inside {K_ST, K_STU})       r.mem_data = in_mem_data;
    return r;
  endfunction

  // Advance the reference model by one clock using the inputs as sampled.
  task automatic model_step();
    bit   do_pop;
    int   size_before;
    rec_t r;
    if (rst) begin
      q.delete();
      m_inum = 0; m_halt_seen = 0; m_ovf = 0; m_halted = 0;
      return;
    end
    size_before = q.size();
    do_pop = (size_before > 0) && out_ready;
    if (do_pop) begin
      if (q[0].kind == K_HALT) m_halted = 1;
      $display("pop  inum=%0d kind=%0d pc=%04h", q[0].inum, q[0].kind, q[0].pc);
      void'(q.pop_front());
    end
    if (in_valid && !m_halt_seen) begin
      r = expected_rec();
      if (size_before < DEPTH || do_pop) q.push_back(r);
      else begin
        m_ovf = 1;
        $display("drop inum=%0d kind=%0d", r.inum, r.kind);
      end
      if (r.kind == K_HALT) m_halt_seen = 1;
      m_inum++;
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, q.size() != 0);
    check("count", count, q.size());
    check("stall_req", stall_req, q.size() >= DEPTH-1);
    check("overflow", overflow, m_ovf);
    check("halted", halted, m_halted);
    if (q.size() != 0) begin
      check("out_inum", out_inum, q[0].inum);
      check("out_pc", out_pc, q[0].pc);
      check("out_kind", out_kind, q[0].kind);
      check("out_reg_idx", out_reg_idx, q[0].reg_idx);
      check("out_reg_data", out_reg_data, q[0].reg_data);
      check("out_mem_addr", out_mem_addr, q[0].mem_addr);
      check("out_mem_data", out_mem_data, q[0].mem_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    in_valid = 0; in_pc = '0; in_reg_wr = 0; in_reg_idx = '0; in_reg_data = '0;
    in_mem_rd = 0; in_mem_wr = 0; in_mem_addr = '0; in_mem_data = '0; in_halt = 0;
  endtask

  task automatic ev(input logic [15:0] pc, input logic rw, input logic [2:0] idx,
                    input logic [15:0] rd, input logic mr, input logic mw,
                    input logic [15:0] addr, input logic [15:0] md, input logic h);
    in_valid = 1; in_pc = pc; in_reg_wr = rw; in_reg_idx = idx; in_reg_data = rd;
    in_mem_rd = mr; in_mem_wr = mw; in_mem_addr = addr; in_mem_data = md; in_halt = h;
  endtask

  task automatic rand_ev(input int halt_pct);
    in_valid    = ($urandom_range(99) < 70);
    in_pc       = 16'($urandom);
    in_reg_wr   = 1'($urandom);
    in_reg_idx  = 3'($urandom);
    in_reg_data = 16'($urandom);
    in_mem_rd   = 1'($urandom);
    in_mem_wr   = 1'($urandom);
    in_mem_addr = 16'($urandom);
    in_mem_data = 16'($urandom);
    in_halt     = ($urandom_range(99) < halt_pct);
  endtask

  task automatic do_reset();
    idle(); rst = 1; out_ready = 0;
    step(); step();
    rst = 0;
  endtask

  initial begin
    idle(); rst = 1; out_ready = 0;
    @(negedge clk);
    do_reset();
    check("reset_out_valid", out_valid, 0);
    check("reset_inum", out_inum, 0);
    check("reset_pc", out_pc, 0);
    check("reset_reg_data", out_reg_data, 0);
    check("reset_mem_addr", out_mem_addr, 0);

    // ALU retire shows on the outputs one cycle later.
    out_ready = 1;
    ev(16'h0002, 1, 3'd3, 16'h00A5, 0, 0, 16'h7777, 16'h8888, 0); step();
    check("tp1_kind", out_kind, K_ALU);
    check("tp1_mem_addr", out_mem_addr, 0);
    idle(); step();

    // STU, LD, NOP in order.
    do_reset();
    ev(16'h0010, 1, 3'd1, 16'h0BEE, 0, 1, 16'h0100, 16'h1234, 0); step();
    ev(16'h0012, 1, 3'd2, 16'h0CAF, 1, 0, 16'h0200, 16'h5555, 0); step();
    ev(16'h0014, 0, 3'd4, 16'h1111, 0, 0, 16'h0300, 16'h6666, 0); step();
    idle(); out_ready = 1;
    repeat (4) step();

    // Fill, overflow, drain, gap in INUM.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ev(16'(i * 2), 1, 3'(i), 16'(i), 0, 0, '0, '0, 0); step();
    end
    check("tp3_overflow", overflow, 1);
    idle(); out_ready = 1;
    repeat (8) step();
    out_ready = 0;
    ev(16'h0040, 0, 3'd0, '0, 0, 1, 16'h0044, 16'h0099, 0); step();
    check("tp3_next_inum", out_inum, 9);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ev(16'(i), 1, 3'd5, 16'(i), 0, 0, '0, '0, 0); step();
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      ev(16'(100 + i), 0, 3'd0, '0, 0, 1, 16'(i), 16'(i), 0); step();
    end
    check("tp4_overflow", overflow, 0);

    // Halt closes the stream; queued records still drain.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ev(16'(i), 1, 3'd2, 16'(i), 0, 0, '0, '0, 0); step();
    end
    idle(); out_ready = 1; step(); step();
    out_ready = 0;
    ev(16'h00F0, 1, 3'd7, 16'hDEAD, 0, 1, 16'h1, 16'h2, 1); step();
    for (int i = 0; i < 3; i++) begin
      ev(16'(200 + i), 1, 3'd1, 16'(i), 0, 0, '0, '0, 0); step();
    end
    idle(); out_ready = 1;
    repeat (5) step();
    check("tp5_halted", halted, 1);

    // Reset mid-operation discards queued records.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ev(16'(i), 0, 3'd0, '0, 0, 1, 16'(i), 16'(i), 0); step();
    end
    idle(); rst = 1; step(); rst = 0;
    check("tp6_count", count, 0);
    ev(16'h0123, 1, 3'd6, 16'h4321, 1, 0, 16'h0050, '0, 0); step();
    check("tp6_inum", out_inum, 0);

    // Randomized traffic at several consumer rates.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        rand_ev(round == 2 ? 2 : 0);
        out_ready = ($urandom_range(99) < 30 + 30 * round);
        rst = ($urandom_range(199) == 0);
        step();
        rst = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
